// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Predicts in fetch, carries the prediction to EX, and trains on resolved branches.
module branch_target_buffer #(
  parameter int ENTRY_BITS = 6,
  parameter bit USE_BHT    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_IF,
  input  logic        bubbleD,
  input  logic        flushD,
  input  logic        bubbleE,
  input  logic        flushE,
  input  logic [31:0] PC_EX,
  input  logic        is_br_EX,
  input  logic        br,
  input  logic [31:0] br_target,
  output logic        PredictF,
  output logic [31:0] PredictPC,
  output logic        PredictE,
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = 30 - ENTRY_BITS;

  logic                  valid  [ENTRIES];
  logic [1:0]            cnt    [ENTRIES];
  logic [TAG_W-1:0]      tag    [ENTRIES];
  logic [31:0]           target [ENTRIES];

  logic [ENTRY_BITS-1:0] idx_f;
  logic [ENTRY_BITS-1:0] idx_e;
  logic [TAG_W-1:0]      tag_f;
  logic [TAG_W-1:0]      tag_e;
  logic                  hit_f;
  logic                  hit_e;
  logic                  upd;
  logic                  predict_d;
  logic                  unused_pc_bits;

  assign idx_f = PC_IF[ENTRY_BITS+1:2];
  assign tag_f = PC_IF[31:ENTRY_BITS+2];
  assign idx_e = PC_EX[ENTRY_BITS+1:2];
  assign tag_e = PC_EX[31:ENTRY_BITS+2];
  assign unused_pc_bits = ^{PC_IF[1:0], PC_EX[1:0]};

  assign hit_f     = valid[idx_f] && (tag[idx_f] == tag_f);
  assign PredictF  = hit_f && (USE_BHT ? cnt[idx_f][1] : 1'b1);
  assign PredictPC = hit_f ? target[idx_f] : 32'h0;

  assign hit_e = valid[idx_e] && (tag[idx_e] == tag_e);
  assign upd   = is_br_EX && !bubbleE;

  // Valid bits and counters are the only reset storage; tag/target stay
  // invisible behind valid=0 until an allocation rewrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        cnt[i]   <= 2'b01;
      end
    end else if (upd) begin
      if (hit_e) begin
        if (br) begin
          if (cnt[idx_e] != 2'b11) cnt[idx_e] <= cnt[idx_e] + 2'd1;
        end else begin
          if (cnt[idx_e] != 2'b00) cnt[idx_e] <= cnt[idx_e] - 2'd1;
        end
      end else if (br) begin
        valid[idx_e] <= 1'b1;
        cnt[idx_e]   <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd && br) begin
      target[idx_e] <= br_target;
      if (!hit_e) tag[idx_e] <= tag_e;
    end
  end

  // Prediction pipe: bubble holds and wins over flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predict_d <= 1'b0;
      PredictE  <= 1'b0;
    end else begin
      if (!bubbleD) predict_d <= flushD ? 1'b0 : PredictF;
      if (!bubbleE) PredictE  <= flushE ? 1'b0 : predict_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt      <= 32'h0;
      mispred_cnt <= 32'h0;
    end else if (upd) begin
      br_cnt <= br_cnt + 32'd1;
      if (br != PredictE) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule
